cdb_sched_issue_unit: RTL and testbench
=======================================

// Module: cdb_sched_issue_unit
// PURPOSE
//  Parametrised issue unit and common-data-bus (CDB) scheduler for the Tomasulo core.
//  Arbitrates NUM_CH reservation-station channels round-robin and issues at most one per cycle.
//  Each channel has a fixed latency; a CDB slot is booked at issue, so results never collide.
//  Registers the booked unit's result onto the CDB. Supersedes the fixed 4-port issue unit.
// PARAMETERS
//  NUM_CH   4          number of execution channels (2..8)
//  TAG_W    6          ROB/physical tag width
//  DATA_W   32         CDB result width
//  MAX_LAT  8          largest legal channel latency (reservation ring depth)
//  CH_LAT   {4'd8,4'd4,4'd2,4'd1}  packed 4b latency per channel, ch0 in LSBs; each 1..MAX_LAT
//  CH_PIPE  4'b0111    bit i=1: channel i accepts an issue every cycle; 0: blocked until its result cycle
// PORTS
//  i_clk         in   1               clock
//  i_rst_n       in   1               async active-low reset
//  flush         in   1               branch mispredict flush
//  ch_rdy        in   NUM_CH          channel i has an issuable instruction
//  issue_grant   out  NUM_CH          one-hot (or zero) grant, combinational, this cycle
//  ch_res_valid  in   NUM_CH          channel i is presenting a result this cycle
//  ch_res_tag    in   NUM_CH*TAG_W    per-channel result tag
//  ch_res_data   in   NUM_CH*DATA_W   per-channel result data
//  cdb_valid     out  1               registered CDB valid
//  cdb_tag       out  TAG_W           registered CDB tag
//  cdb_data      out  DATA_W          registered CDB data
//  cdb_src       out  $clog2(NUM_CH)  channel that drove the CDB
//  proto_err     out  1               sticky: booked channel failed to present a result
// BEHAVIOUR
//  Reset: ring, owners, busy counters, rr_ptr=0, all cdb_* = 0, proto_err = 0, issue_grant = 0.
//  Ring rsv[0..MAX_LAT]: rsv[k] = CDB slot for cycle c+k is booked; own[k] = booking channel.
//  Eligible(i) = ch_rdy[i] & !rsv[CH_LAT[i]] & (CH_PIPE[i] | busy_cnt[i]==0) & !flush.
//  Grant = first eligible channel scanning from rr_ptr upward (mod NUM_CH). On grant g, rr_ptr <= g+1.
//  Update each edge: rsv[k] <= rsv[k+1]; rsv[MAX_LAT] <= 0; then the grant sets rsv[CH_LAT[g]-1] and own[...] = g.
//   So an issue in cycle c owns slot c+L.
//  Non-pipelined: on grant, busy_cnt[g] <= CH_LAT[g]-1. It decrements to 0, so the channel is eligible again at c+L.
//  Result capture: if rsv[0], sample channel own[0] (ch_res_tag/data) into cdb_* at the edge.
//   cdb_valid is high in cycle c+L+1 (issue-to-CDB = L+1 cycles).
//   If ch_res_valid[own[0]]==0: cdb_valid <= 0 and proto_err <= 1.
//   No rsv[0]: cdb_valid <= 0. ch_res_valid outside a booked slot is ignored.
//  L=1 channels may issue back-to-back; a slot conflict defers the channel, and rr_ptr does not advance past it.
//  Flush: issue_grant forced 0 that cycle. Next edge clears rsv, own, busy_cnt and cdb_valid. rr_ptr and proto_err are kept.
//  Flush and result capture in the same cycle: the result is dropped (cdb_valid=0).
//  Async reset mid-operation: immediate return to reset state, with no pending CDB writes.
//  Width rules: CH_LAT slices are unsigned 4b; index math is in $clog2(MAX_LAT+1) bits.
//   Elaboration $error if any latency is 0 or > MAX_LAT.
// STRUCTURE
//  Package cdb_sched_pkg: ch_idx_t, lat_t, the rsv-slot struct {valid, owner}, and the CH_LAT slice function.
//  Sub-module rr_arbiter #(N): request/pointer -> one-hot grant and granted index. The ring and capture logic stay in the top.
//  Core top instantiates one unit. The four RS issue_rdy lines feed ch_rdy and issue_grant returns issue_done.
// TESTING
//  1 Reset: hold i_rst_n=0 with ch_rdy=4'hF -> issue_grant=0, cdb_valid=0, proto_err=0.
//  2 ch_rdy=4'b0001 for 3 cycles, ch0 returns tags 1,2,3 at c+1..c+3 -> cdb_tag 1,2,3 in c+2..c+4, cdb_src=0.
//  3 Collision: grant ch2 (L=4) at c0; ch0 (L=1) ready at c3 -> no grant at c3 (slot c4 booked); ch0 granted c4. cdb_src 2 then 0.
//  4 Non-pipe ch3 (L=8), ch_rdy[3] held high -> grants at c0 and c8 only, with ch0 granted in between.
//  5 ch_rdy=4'hF on an empty ring with rr_ptr=0 -> grants in order 0,1,2,3; rr_ptr wraps to 0.
//  6 Flush at c2 after a ch2 grant at c0 -> no CDB at c5. A missing ch_res_valid on a booked slot -> proto_err=1 and stays set.

Source files
------------

// File: rtl/cdb_sched_pkg.sv
// cdb_sched_pkg: shared types and helpers for the CDB scheduler / issue unit.
// Widths cover the largest legal configuration (8 channels, 4-bit latencies).
package cdb_sched_pkg;
  localparam int CH_IDX_W = 3;
  localparam int LAT_W = 4;
  localparam int MAX_CH = 8;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;
  typedef logic [LAT_W-1:0] lat_t;
  typedef struct packed {
    logic    valid;
    ch_idx_t owner;
  } rsv_slot_t;
  function automatic lat_t ch_lat(input logic [MAX_CH*LAT_W-1:0] lats, input int i);
    return lats[i*LAT_W +: LAT_W];
  endfunction
endpackage

// File: rtl/cdb_sched_issue_unit_rr_arbiter.sv
// rr_arbiter: first requester at or above ptr (wrapping) wins; one-hot grant plus its index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // scan from the farthest offset down so the nearest requester is written last
    for (int o = N - 1; o >= 0; o--) begin
      if (req[(int'(ptr) + o) % N]) begin
        idx = ($clog2(N))'((int'(ptr) + o) % N);
        any = 1'b1;
      end
    end
  end
  assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/cdb_sched_issue_unit.sv
// cdb_sched_issue_unit: round-robin issue across NUM_CH channels with a CDB slot booked at issue,
// so fixed-latency results never collide; the booked channel's result is registered onto the CDB.
module cdb_sched_issue_unit
  import cdb_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TAG_W = 6,
  parameter int DATA_W = 32,
  parameter int MAX_LAT = 8,
  parameter logic [4*NUM_CH-1:0] CH_LAT = {4'd8, 4'd4, 4'd2, 4'd1},
  parameter logic [NUM_CH-1:0] CH_PIPE = 4'b0111
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          ch_rdy,
  output logic [NUM_CH-1:0]          issue_grant,
  input  logic [NUM_CH-1:0]          ch_res_valid,
  input  logic [NUM_CH*TAG_W-1:0]    ch_res_tag,
  input  logic [NUM_CH*DATA_W-1:0]   ch_res_data,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_CH)-1:0]  cdb_src,
  output logic                       proto_err
);
  localparam int SW = $clog2(NUM_CH);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam logic [MAX_CH*LAT_W-1:0] LATS = (MAX_CH*LAT_W)'(CH_LAT);
  rsv_slot_t         rsv [MAX_LAT+1];
  logic [LW-1:0]     busy_cnt [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [SW-1:0]     rr_ptr, g_idx, own0;
  logic              g_any;
  lat_t              g_lat;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int L = int'(ch_lat(LATS, i));
    if (L == 0 || L > MAX_LAT) begin : g_bad
      $error("channel %0d latency %0d outside 1..%0d", i, L, MAX_LAT);
    end
    // rsv[L] is the CDB slot this channel's result would land in if issued now
    assign elig[i] = i_rst_n & ~flush & ch_rdy[i] & ~rsv[L].valid & (CH_PIPE[i] | (busy_cnt[i] == '0));
  end
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (issue_grant),
    .idx (g_idx),
    .any (g_any)
  );
  assign g_lat = ch_lat(LATS, int'(g_idx));
  assign own0 = SW'(rsv[0].owner);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= MAX_LAT; k++) rsv[k] <= '0;
      for (int i = 0; i < NUM_CH; i++) busy_cnt[i] <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_src <= '0;
      proto_err <= 1'b0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) rsv[k] <= flush ? '0 : rsv[k+1];
      rsv[MAX_LAT] <= '0;
      // the ring shifts this edge, so slot L lands at index L-1
      if (g_any) begin
        rsv[LW'(g_lat - lat_t'(1))] <= '{valid: 1'b1, owner: ch_idx_t'(g_idx)};
        rr_ptr <= (g_idx == SW'(NUM_CH - 1)) ? '0 : g_idx + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (flush) busy_cnt[i] <= '0;
        else if (g_any && g_idx == SW'(i) && !CH_PIPE[i]) busy_cnt[i] <= LW'(ch_lat(LATS, i) - lat_t'(1));
        else if (busy_cnt[i] != '0) busy_cnt[i] <= busy_cnt[i] - 1'b1;
      end
      cdb_valid <= 1'b0;
      if (rsv[0].valid && !flush) begin
        if (ch_res_valid[own0]) begin
          cdb_valid <= 1'b1;
          cdb_tag <= ch_res_tag[own0*TAG_W +: TAG_W];
          cdb_data <= ch_res_data[own0*DATA_W +: DATA_W];
          cdb_src <= own0;
        end else begin
          proto_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_sched_issue_unit.sv
// tb_cdb_sched_issue_unit: randomized and directed stimulus against a cycle-indexed booking model.
module tb_cdb_sched_issue_unit;
  localparam int N = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int ML = 8;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0] ch_rdy = '0;
  logic [N-1:0] issue_grant;
  logic [N-1:0] ch_res_valid = '0;
  logic [N*TW-1:0] ch_res_tag = '0;
  logic [N*DW-1:0] ch_res_data = '0;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0] cdb_src;
  logic proto_err;
  cdb_sched_issue_unit #(
    .NUM_CH(N), .TAG_W(TW), .DATA_W(DW), .MAX_LAT(ML),
    .CH_LAT({4'd8, 4'd4, 4'd2, 4'd1}), .CH_PIPE(4'b0111)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(flush), .ch_rdy(ch_rdy), .issue_grant(issue_grant),
    .ch_res_valid(ch_res_valid), .ch_res_tag(ch_res_tag), .ch_res_data(ch_res_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src), .proto_err(proto_err)
  );
  always #5 i_clk = ~i_clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr = 0;
  int lat_tab [N] = '{1, 2, 4, 8};
  bit pipe_tab [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int slot_own [int];
  int last_iss [N];
  bit e_valid = 1'b0;
  bit e_perr = 1'b0;
  logic [TW-1:0] e_tag = '0;
  logic [DW-1:0] e_data = '0;
  int e_src = 0;
  logic [N-1:0] gs;
  logic [N-1:0] e5 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [N-1:0] e4 [9] = '{4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    slot_own.delete();
    for (int i = 0; i < N; i++) last_iss[i] = -1000;
    rr = 0;
    e_valid = 1'b0;
    e_perr = 1'b0;
  endtask
  // One clock cycle: check registered outputs, drive inputs, check grant, advance the model.
  task automatic step(input logic [N-1:0] rdy, input bit fl, input bit drop, output logic [N-1:0] g_seen);
    int g, o, i;
    bit bk;
    chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    if (e_valid) begin
      chk("cdb_tag", 64'(cdb_tag), 64'(e_tag));
      chk("cdb_data", 64'(cdb_data), 64'(e_data));
      chk("cdb_src", 64'(cdb_src), 64'(e_src));
    end
    chk("proto_err", 64'(proto_err), 64'(e_perr));
    ch_rdy = rdy;
    flush = fl;
    ch_res_valid = N'($urandom);
    ch_res_tag = (N*TW)'($urandom);
    for (int c = 0; c < N; c++) ch_res_data[c*DW +: DW] = $urandom;
    bk = slot_own.exists(cyc);
    o = bk ? slot_own[cyc] : 0;
    if (bk) ch_res_valid[o] = !drop;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      if (g < 0 && rdy[i] && !fl && !slot_own.exists(cyc + lat_tab[i]) &&
          (pipe_tab[i] || cyc >= last_iss[i] + lat_tab[i])) g = i;
    end
    g_seen = issue_grant;
    chk("issue_grant", 64'(issue_grant), (g < 0) ? 64'd0 : (64'd1 << g));
    e_valid = 1'b0;
    if (bk && !fl) begin
      if (drop) e_perr = 1'b1;
      else begin
        e_valid = 1'b1;
        e_tag = ch_res_tag[o*TW +: TW];
        e_data = ch_res_data[o*DW +: DW];
        e_src = o;
      end
    end
    if (fl) begin
      for (int k = 0; k <= ML; k++) if (slot_own.exists(cyc + k)) slot_own.delete(cyc + k);
      for (int c = 0; c < N; c++) last_iss[c] = -1000;
    end
    if (g >= 0) begin
      slot_own[cyc + lat_tab[g]] = g;
      last_iss[g] = cyc;
      rr = (g + 1) % N;
    end
    if (slot_own.exists(cyc)) slot_own.delete(cyc);
    @(posedge i_clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    logic [N-1:0] x;
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, x);
  endtask
  task automatic rnd(input int n);
    logic [N-1:0] x;
    for (int k = 0; k < n; k++) step(N'($urandom), ($urandom % 16) == 0, 1'b0, x);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    ch_rdy = '1;
    #3;
    chk("rst_grant", 64'(issue_grant), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 1'b0, 1'b0, gs);
      chk("t5_rr_order", 64'(gs), 64'(e5[k]));
    end
    idle(12);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b0, 1'b0, gs);
      chk("t2_grant", 64'(gs), 64'd1);
    end
    for (int k = 0; k < 2; k++) begin
      chk("t2_cdb_valid", 64'(cdb_valid), 64'd1);
      chk("t2_cdb_src", 64'(cdb_src), 64'd0);
      idle(1);
    end
    idle(10);
    step(4'b0100, 1'b0, 1'b0, gs);
    chk("t3_grant_ch2", 64'(gs), 64'h4);
    idle(2);
    step(4'b0001, 1'b0, 1'b0, gs);
    chk("t3_slot_conflict", 64'(gs), 64'h0);
    step(4'b0001, 1'b0, 1'b0, gs);
    chk("t3_deferred_ch0", 64'(gs), 64'h1);
    chk("t3_src_first", 64'(cdb_src), 64'd2);
    chk("t3_valid_first", 64'(cdb_valid), 64'd1);
    idle(1);
    chk("t3_src_second", 64'(cdb_src), 64'd0);
    idle(10);
    for (int k = 0; k < 9; k++) begin
      step(4'b1001, 1'b0, 1'b0, gs);
      chk("t4_nonpipe_seq", 64'(gs), 64'(e4[k]));
    end
    idle(12);
    rnd(300);
    idle(12);
    step(4'b0100, 1'b0, 1'b0, gs);
    chk("t6_grant_ch2", 64'(gs), 64'h4);
    idle(1);
    step(4'hF, 1'b1, 1'b0, gs);
    chk("t6_flush_grant", 64'(gs), 64'h0);
    idle(2);
    chk("t6_no_cdb_after_flush", 64'(cdb_valid), 64'd0);
    idle(4);
    step(4'b0001, 1'b0, 1'b0, gs);
    step('0, 1'b0, 1'b1, gs);
    chk("t6_proto_err_set", 64'(proto_err), 64'd1);
    idle(3);
    chk("t6_proto_err_sticky", 64'(proto_err), 64'd1);
    rnd(40);
    step(4'hF, 1'b0, 1'b0, gs);
    ch_rdy = 4'hF;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_grant", 64'(issue_grant), 64'd0);
    chk("mid_rst_proto_err", 64'(proto_err), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    cyc++;
    rnd(40);
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
